// File: rtl/core_defs_pkg.sv
// Shared encodings between the microcoded control unit and the datapath:
// bus source codes, load-enable bit positions, increment bits and ALU opcodes.
package core_defs_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;
  localparam int unsigned WR_W           = 19;

  typedef enum logic [4:0] {
    RD_NONE  = 5'd0,
    RD_IR    = 5'd1,
    RD_PC    = 5'd2,
    RD_DR    = 5'd3,
    RD_RA    = 5'd4,
    RD_RB    = 5'd5,
    RD_RO    = 5'd6,
    RD_RN    = 5'd7,
    RD_RP    = 5'd8,
    RD_RC    = 5'd9,
    RD_RR    = 5'd10,
    RD_RT    = 5'd11,
    RD_AC    = 5'd12,
    RD_DRAM  = 5'd13,
    RD_IRTR  = 5'd14,
    RD_ACHI  = 5'd15,
    RD_RCOL1 = 5'd16,
    RD_RCOL2 = 5'd17
  } rd_src_e;

  localparam int unsigned WR_AR    = 0;
  localparam int unsigned WR_PC    = 1;
  localparam int unsigned WR_IR    = 2;
  localparam int unsigned WR_TR    = 3;
  localparam int unsigned WR_DR    = 4;
  localparam int unsigned WR_RA    = 5;  // RA..RT occupy bits 5..12
  localparam int unsigned WR_R     = 13;
  localparam int unsigned WR_AC    = 14;
  localparam int unsigned WR_ALU   = 15;
  localparam int unsigned WR_DRAM  = 16;
  localparam int unsigned WR_RCOL1 = 17;
  localparam int unsigned WR_RCOL2 = 18;

  localparam int unsigned INC_PC = 0;
  localparam int unsigned INC_AC = 1;

  typedef enum logic [2:0] {
    ALU_NOP  = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_MUL  = 3'd3,
    ALU_DEC  = 3'd4,
    ALU_CLR  = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

endpackage

// File: rtl/core_alu.sv
// Combinational ALU operating on AC and R; all results wrap to DATA_W bits.
module core_alu
  import core_defs_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] ac_i,
  input  logic [DATA_W-1:0] r_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = ac_i;
    case (op_i)
      ALU_ADD: result_o = ac_i + r_i;
      ALU_SUB: result_o = ac_i - r_i;
      ALU_MUL: result_o = ac_i * r_i;
      ALU_DEC: result_o = ac_i - DATA_W'(1);
      ALU_CLR: result_o = '0;
      ALU_XOR: result_o = ac_i ^ r_i;
      default: result_o = ac_i;
    endcase
  end

endmodule

// File: rtl/processor_datapath.sv
// Register-transfer datapath: bus mux, register file, AC/PC increment and z flag,
// driven each cycle by the micro-operation fields of the control unit.
module processor_datapath
  import core_defs_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned PC_W    = 8,
  parameter int unsigned DADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         read_en,
  input  logic [WR_W-1:0]    write_en,
  input  logic [1:0]         inc_en,
  input  logic [2:0]         alu_op,
  input  logic [7:0]         iram_rdata,
  input  logic [7:0]         dram_rdata,
  output logic [PC_W-1:0]    iram_addr,
  output logic [DADDR_W-1:0] dram_addr,
  output logic [7:0]         dram_wdata,
  output logic               dram_we,
  output logic [7:0]         instruction,
  output logic               z
);

  logic [PC_W-1:0]             pc_q, pc_d;
  logic [7:0]                  ir_q, ir_d, tr_q, tr_d, dr_q, dr_d;
  logic [DADDR_W-1:0]          ar_q, ar_d;
  logic [DATA_W-1:0]           ac_q, ac_d, r_q, r_d;
  logic [DATA_W-1:0]           rcol1_q, rcol1_d, rcol2_q, rcol2_d;
  logic [7:0][DATA_W-1:0]      gp_q, gp_d;  // RA, RB, RO, RN, RP, RC, RR, RT
  logic                        z_q, z_d;
  logic [DATA_W-1:0]           bus;
  logic [DATA_W-1:0]           alu_res;

  core_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .ac_i    (ac_q),
    .r_i     (r_q),
    .op_i    (alu_op_e'(alu_op)),
    .result_o(alu_res)
  );

  // Narrow sources are zero-extended by the '0 default.
  always_comb begin
    bus = '0;
    case (read_en)
      RD_IR:    bus[7:0] = ir_q;
      RD_PC:    bus[PC_W-1:0] = pc_q;
      RD_DR:    bus[7:0] = dr_q;
      RD_RA:    bus = gp_q[0];
      RD_RB:    bus = gp_q[1];
      RD_RO:    bus = gp_q[2];
      RD_RN:    bus = gp_q[3];
      RD_RP:    bus = gp_q[4];
      RD_RC:    bus = gp_q[5];
      RD_RR:    bus = gp_q[6];
      RD_RT:    bus = gp_q[7];
      RD_AC:    bus = ac_q;
      RD_DRAM:  bus[7:0] = dram_rdata;
      RD_IRTR:  bus[15:0] = {ir_q, tr_q};
      RD_ACHI:  bus[7:0] = ac_q[15:8];
      RD_RCOL1: bus = rcol1_q;
      RD_RCOL2: bus = rcol2_q;
      default:  bus = '0;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    tr_d    = tr_q;
    dr_d    = dr_q;
    ar_d    = ar_q;
    ac_d    = ac_q;
    r_d     = r_q;
    rcol1_d = rcol1_q;
    rcol2_d = rcol2_q;
    gp_d    = gp_q;
    z_d     = z_q;

    if (write_en[WR_AR])    ar_d = DADDR_W'(bus);
    if (write_en[WR_IR])    ir_d = iram_rdata;
    if (write_en[WR_TR])    tr_d = bus[7:0];
    if (write_en[WR_DR])    dr_d = bus[7:0];
    if (write_en[WR_R])     r_d = bus;
    if (write_en[WR_RCOL1]) rcol1_d = bus;
    if (write_en[WR_RCOL2]) rcol2_d = bus;
    for (int i = 0; i < 8; i++) begin
      if (write_en[WR_RA+i]) gp_d[i] = bus;
    end

    if (write_en[WR_PC]) begin
      pc_d = bus[PC_W-1:0];
    end else if (inc_en[INC_PC]) begin
      pc_d = pc_q + PC_W'(1);
    end

    // Bus load beats ALU; the increment rides on whichever AC source is chosen,
    // except that an ALU write swallows it. z follows only ALU/increment updates.
    if (write_en[WR_AC]) begin
      if (inc_en[INC_AC]) begin
        ac_d = bus + DATA_W'(1);
        z_d  = (ac_d == '0);
      end else begin
        ac_d = bus;
      end
    end else if (write_en[WR_ALU]) begin
      ac_d = alu_res;
      z_d  = (ac_d == '0);
    end else if (inc_en[INC_AC]) begin
      ac_d = ac_q + DATA_W'(1);
      z_d  = (ac_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= '0;
      tr_q    <= '0;
      dr_q    <= '0;
      ar_q    <= '0;
      ac_q    <= '0;
      r_q     <= '0;
      rcol1_q <= '0;
      rcol2_q <= '0;
      gp_q    <= '0;
      z_q     <= 1'b1;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tr_q    <= tr_d;
      dr_q    <= dr_d;
      ar_q    <= ar_d;
      ac_q    <= ac_d;
      r_q     <= r_d;
      rcol1_q <= rcol1_d;
      rcol2_q <= rcol2_d;
      gp_q    <= gp_d;
      z_q     <= z_d;
    end
  end

  assign iram_addr   = pc_q;
  assign dram_addr   = ar_q;
  assign dram_wdata  = bus[7:0];
  assign dram_we     = write_en[WR_DRAM];
  assign instruction = ir_q;
  assign z           = z_q;

endmodule

// File: tb/tb_processor_datapath.sv
// Randomised + directed bench for processor_datapath; a register-array reference model
// feeds a scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_processor_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_en;
  logic [18:0] write_en;
  logic [1:0]  inc_en;
  logic [2:0]  alu_op;
  logic [7:0]  iram_rdata, dram_rdata;
  logic [7:0]  iram_addr;
  logic [15:0] dram_addr;
  logic [7:0]  dram_wdata;
  logic        dram_we;
  logic [7:0]  instruction;
  logic        z;

  processor_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .read_en    (read_en),
    .write_en   (write_en),
    .inc_en     (inc_en),
    .alu_op     (alu_op),
    .iram_rdata (iram_rdata),
    .dram_rdata (dram_rdata),
    .iram_addr  (iram_addr),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_we    (dram_we),
    .instruction(instruction),
    .z          (z)
  );

  always #5 clk = ~clk;

  // Reference state. Register file indexed by name order: RA RB RO RN RP RC RR RT.
  logic [7:0]  m_pc, m_ir, m_tr, m_dr;
  logic [15:0] m_ar, m_ac, m_r, m_c1, m_c2;
  logic [15:0] m_gp [8];
  logic        m_z;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ar;
    logic [7:0]  ir;
    logic        z;
    logic [7:0]  wd;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 0; m_ir = 0; m_tr = 0; m_dr = 0;
    m_ar = 0; m_ac = 0; m_r = 0; m_c1 = 0; m_c2 = 0;
    foreach (m_gp[i]) m_gp[i] = 0;
    m_z = 1'b1;
  endtask

  function automatic logic [15:0] m_bus(input int sel, input logic [7:0] drd);
    logic [15:0] src [18];
    src[0] = 0;          src[1] = {8'h00, m_ir};  src[2] = {8'h00, m_pc};
    src[3] = {8'h00, m_dr};
    for (int i = 0; i < 8; i++) src[4+i] = m_gp[i];
    src[12] = m_ac;      src[13] = {8'h00, drd};  src[14] = {m_ir, m_tr};
    src[15] = {8'h00, m_ac[15:8]};
    src[16] = m_c1;      src[17] = m_c2;
    return (sel < 18) ? src[sel] : 16'h0000;
  endfunction

  function automatic logic [15:0] m_alu(input int op);
    longint a = m_ac;
    longint b = m_r;
    longint res;
    case (op)
      1: res = a + b;
      2: res = a - b;
      3: res = a * b;
      4: res = a - 1;
      5: res = 0;
      6: res = a ^ b;
      default: res = a;
    endcase
    return res[15:0];
  endfunction

  task automatic m_edge(input logic [4:0] rd, input logic [18:0] wr, input logic [1:0] inc,
                        input logic [2:0] op, input logic [7:0] ird, input logic [7:0] drd);
    logic [15:0] b   = m_bus(int'(rd), drd);
    logic [15:0] alu = m_alu(int'(op));
    logic [16:0] sum;
    if (wr[0]) m_ar = b;
    if (wr[2]) m_ir = ird;
    if (wr[3]) m_tr = b[7:0];
    if (wr[4]) m_dr = b[7:0];
    for (int i = 0; i < 8; i++) if (wr[5+i]) m_gp[i] = b;
    if (wr[13]) m_r = b;
    if (wr[17]) m_c1 = b;
    if (wr[18]) m_c2 = b;
    if (wr[1]) m_pc = b[7:0];
    else if (inc[0]) m_pc = (m_pc == 8'hFF) ? 8'h00 : m_pc + 8'd1;
    if (wr[14]) begin
      if (inc[1]) begin
        sum = {1'b0, b} + 17'd1;
        m_ac = sum[15:0];
        m_z = (m_ac == 0);
      end else begin
        m_ac = b;
      end
    end else if (wr[15]) begin
      m_ac = alu;
      m_z = (m_ac == 0);
    end else if (inc[1]) begin
      sum = {1'b0, m_ac} + 17'd1;
      m_ac = sum[15:0];
      m_z = (m_ac == 0);
    end
  endtask

  // Applies one micro-op for one cycle; called just after a rising edge.
  task automatic step(input logic [4:0] rd, input logic [18:0] wr, input logic [1:0] inc,
                      input logic [2:0] op, input logic [7:0] ird, input logic [7:0] drd,
                      input logic r = 1'b0);
    exp_t e;
    logic [15:0] b;
    read_en = rd; write_en = wr; inc_en = inc; alu_op = op;
    iram_rdata = ird; dram_rdata = drd; rst = r;
    b = m_bus(int'(rd), drd);
    e.pc = m_pc; e.ar = m_ar; e.ir = m_ir; e.z = m_z; e.wd = b[7:0]; e.we = wr[16];
    exp_q.push_back(e);
    @(posedge clk);
    if (r) m_reset();
    else m_edge(rd, wr, inc, op, ird, drd);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("iram_addr",   {8'h00, iram_addr},   {8'h00, e.pc});
      chk("dram_addr",   dram_addr,            e.ar);
      chk("instruction", {8'h00, instruction}, {8'h00, e.ir});
      chk("z",           {15'h0, z},           {15'h0, e.z});
      chk("dram_wdata",  {8'h00, dram_wdata},  {8'h00, e.wd});
      chk("dram_we",     {15'h0, dram_we},     {15'h0, e.we});
    end
  end

  localparam logic [18:0] W0 = 19'h0;

  initial begin
    logic [18:0] wr;
    rst = 1'b1; write_en = '1; read_en = 0; inc_en = 0; alu_op = 0;
    iram_rdata = 0; dram_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    // Reset must override every enable in the same cycle.
    step(5'd13, '1, 2'b11, 3'd1, 8'hAA, 8'h55, 1'b1);
    step(5'd0, W0, 2'b00, 3'd0, 8'h00, 8'h00);

    // Load immediate via IR/TR.
    step(5'd0,  19'h1 << 2,  2'b01, 3'd0, 8'h12, 8'h00);
    step(5'd1,  19'h1 << 3,  2'b00, 3'd0, 8'h00, 8'h00);
    step(5'd0,  19'h1 << 2,  2'b00, 3'd0, 8'h34, 8'h00);
    step(5'd14, 19'h1 << 14, 2'b00, 3'd0, 8'h00, 8'h00);
    step(5'd12, 19'h1 << 0,  2'b00, 3'd0, 8'h00, 8'h00);

    // Arithmetic: MUL, SUB to zero, DEC to FFFF.
    step(5'd13, 19'h1 << 14, 2'b00, 3'd0, 8'h00, 8'h03);
    step(5'd13, 19'h1 << 13, 2'b00, 3'd0, 8'h00, 8'h05);
    step(5'd0,  19'h1 << 15, 2'b00, 3'd3, 8'h00, 8'h00);
    step(5'd13, 19'h1 << 13, 2'b00, 3'd0, 8'h00, 8'h0F);
    step(5'd0,  19'h1 << 15, 2'b00, 3'd2, 8'h00, 8'h00);
    step(5'd0,  19'h1 << 15, 2'b00, 3'd4, 8'h00, 8'h00);
    step(5'd12, 19'h1 << 0,  2'b00, 3'd0, 8'h00, 8'h00);

    // Store path: AC <- RO+1, then DRAM write strobe.
    step(5'd13, 19'h1 << 7,  2'b00, 3'd0, 8'h00, 8'h40);
    step(5'd6,  19'h1 << 14, 2'b10, 3'd0, 8'h00, 8'h00);
    step(5'd12, 19'h1 << 16, 2'b00, 3'd0, 8'h00, 8'h00);

    // Memory load with idle cycle between AR load and capture.
    step(5'd13, 19'h1 << 14, 2'b00, 3'd0, 8'h00, 8'h20);
    step(5'd12, 19'h1 << 0,  2'b00, 3'd0, 8'h00, 8'h00);
    step(5'd0,  W0,          2'b00, 3'd0, 8'h00, 8'h00);
    step(5'd13, (19'h1 << 14) | (19'h1 << 4), 2'b00, 3'd0, 8'h00, 8'hA5);
    step(5'd3,  19'h1 << 0,  2'b00, 3'd0, 8'h00, 8'h00);
    step(5'd12, 19'h1 << 0,  2'b00, 3'd0, 8'h00, 8'h00);

    // PC wrap and load-over-increment priority.
    step(5'd13, 19'h1 << 1,  2'b00, 3'd0, 8'h00, 8'hFF);
    step(5'd0,  W0,          2'b01, 3'd0, 8'h00, 8'h00);
    step(5'd13, 19'h1 << 1,  2'b01, 3'd0, 8'h00, 8'h07);

    // AC wrap on increment, then unused source leaves z alone.
    step(5'd0,  19'h1 << 2,  2'b00, 3'd0, 8'hFF, 8'h00);
    step(5'd13, 19'h1 << 3,  2'b00, 3'd0, 8'h00, 8'hFF);
    step(5'd14, 19'h1 << 14, 2'b00, 3'd0, 8'h00, 8'h00);
    step(5'd0,  W0,          2'b10, 3'd0, 8'h00, 8'h00);
    step(5'd13, 19'h1 << 14, 2'b00, 3'd0, 8'h00, 8'h09);
    step(5'd20, 19'h1 << 14, 2'b00, 3'd0, 8'h00, 8'h00);
    step(5'd12, 19'h1 << 0,  2'b00, 3'd0, 8'h00, 8'h00);

    // Mid-sequence reset.
    step(5'd12, 19'h1 << 15, 2'b11, 3'd1, 8'h00, 8'h00, 1'b1);

    for (int n = 0; n < 600; n++) begin
      wr = 19'($urandom) & 19'($urandom) & 19'($urandom);
      if ($urandom_range(1, 0) == 1) wr[0] = 1'b1;
      if (wr[14]) wr[15] = 1'b0;  // combined bus+ALU load left out of random mix
      step(5'($urandom_range(23, 0)), wr, 2'($urandom), 3'($urandom),
           8'($urandom), 8'($urandom), ($urandom_range(49, 0) == 0));
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
